// File: rtl/serdes_ecc_lanes_if.sv
// Bus bundle for the multi-lane SECDED serdes loopback: host-side write/read
// traffic, error-injection control, counters and serial-link observability.
interface serdes_ecc_lanes_if #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 1,
    parameter int CNT_W      = 16
);
    // Smallest Hamming parity count covering payload plus parity bits plus overall bit.
    function automatic int calc_p(input int dw);
        int r;
        r = 0;
        for (int p = 31; p >= 1; p--)
            if ((1 << p) >= dw + p + 1) r = p;
        return r;
    endfunction

    localparam int P  = calc_p(DATA_WIDTH);
    localparam int CW = DATA_WIDTH + P + 1;

    logic [DATA_WIDTH-1:0] parallel_in_i;
    logic                  valid_in_i;
    logic                  ready_out_o;
    logic [CW-1:0]         inject_mask_i;
    logic [DATA_WIDTH-1:0] parallel_out_o;
    logic                  valid_out_o;
    logic                  err_corrected_o;
    logic                  err_uncorrectable_o;
    logic [CNT_W-1:0]      corr_count_o;
    logic [CNT_W-1:0]      uncorr_count_o;
    logic                  cnt_clear_i;
    logic [LANES-1:0]      serial_data_o;
    logic                  serial_valid_o;
    logic                  fifo_full_o;
    logic                  fifo_empty_o;

    modport master (
        output parallel_in_i, valid_in_i, inject_mask_i, cnt_clear_i,
        input  ready_out_o, parallel_out_o, valid_out_o, err_corrected_o,
               err_uncorrectable_o, corr_count_o, uncorr_count_o,
               serial_data_o, serial_valid_o, fifo_full_o, fifo_empty_o
    );

    modport slave (
        input  parallel_in_i, valid_in_i, inject_mask_i, cnt_clear_i,
        output ready_out_o, parallel_out_o, valid_out_o, err_corrected_o,
               err_uncorrectable_o, corr_count_o, uncorr_count_o,
               serial_data_o, serial_valid_o, fifo_full_o, fifo_empty_o
    );
endinterface

// File: rtl/serdes_ecc_lanes.sv
// ECC link test vehicle: FIFO -> SECDED encode -> error mask -> LANES-wide
// serialiser -> deserialiser -> decode/correct, with saturating error counters.
module serdes_ecc_lanes #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int LANES      = 1,
    parameter int CNT_W      = 16
) (
    input logic               clk_i,
    input logic               rst_n_i,
    serdes_ecc_lanes_if.slave bus
);
    function automatic int calc_p(input int dw);
        int r;
        r = 0;
        for (int p = 31; p >= 1; p--)
            if ((1 << p) >= dw + p + 1) r = p;
        return r;
    endfunction

    localparam int P  = calc_p(DATA_WIDTH);
    localparam int CW = DATA_WIDTH + P + 1;
    localparam int B  = (CW + LANES - 1) / LANES;
    localparam int FW = B * LANES;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int BW = (B > 1) ? $clog2(B) : 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // Payload bits fill the non-power-of-2 positions from 3 upward; bit 0 is overall parity.
    function automatic logic [CW-1:0] encode(input logic [DATA_WIDTH-1:0] d);
        logic [CW-1:0] c;
        int j;
        c = '0;
        j = 0;
        for (int pos = 1; pos < CW; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                c[pos] = d[j];
                j++;
            end
        end
        for (int i = 0; i < P; i++)
            for (int pos = 1; pos < CW; pos++)
                if ((((pos >> i) & 1) == 1) && (pos != (1 << i)))
                    c[1 << i] = c[1 << i] ^ c[pos];
        c[0] = ^c[CW-1:1];
        return c;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] extract(input logic [CW-1:0] c);
        logic [DATA_WIDTH-1:0] d;
        int j;
        d = '0;
        j = 0;
        for (int pos = 1; pos < CW; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                d[j] = c[pos];
                j++;
            end
        end
        return d;
    endfunction

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           occ;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;

    logic [0:0]            state;
    logic [BW-1:0]         beat;
    logic                  last_beat;
    logic [FW-1:0]         tx_shreg;
    logic [LANES-1:0]      serial;

    logic [CW-1:0]         rx_word;
    logic                  frame_done;
    int                    dec_syn;
    logic [CW-1:0]         dec_fixed;
    logic                  dec_corr;
    logic                  dec_uncorr;
    logic [DATA_WIDTH-1:0] dec_data;

    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic                  corr_q;
    logic                  uncorr_q;
    logic [CNT_W-1:0]      corr_cnt;
    logic [CNT_W-1:0]      uncorr_cnt;

    assign full      = (occ == (AW+1)'(FIFO_DEPTH));
    assign empty     = (occ == '0);
    assign push      = bus.valid_in_i && !full;
    assign pop       = (state == ST_IDLE) && !empty;
    assign last_beat = (beat == BW'(B - 1));
    assign serial    = (state == ST_SHIFT) ? tx_shreg[LANES-1:0] : '0;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= bus.parallel_in_i;
    end

    // Pop, encode and mask in one step; the shifter then empties itself over B beats.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state    <= ST_IDLE;
            beat     <= '0;
            tx_shreg <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!empty) begin
                        tx_shreg <= FW'(encode(mem[rd_ptr]) ^ bus.inject_mask_i);
                        beat     <= '0;
                        state    <= ST_SHIFT;
                    end
                end
                default: begin
                    tx_shreg <= tx_shreg >> LANES;
                    if (last_beat) begin
                        beat  <= '0;
                        state <= ST_IDLE;
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
            endcase
        end
    end

    // Beats land at their frame position directly, so pad lanes beyond CW are dropped.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rx_word    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= (state == ST_SHIFT) && last_beat;
            if (state == ST_SHIFT) begin
                for (int k = 0; k < LANES; k++)
                    if (int'(beat) * LANES + k < CW)
                        rx_word[int'(beat) * LANES + k] <= serial[k];
            end
        end
    end

    always_comb begin
        dec_syn = 0;
        for (int pos = 1; pos < CW; pos++)
            if (rx_word[pos]) dec_syn = dec_syn ^ pos;
        dec_fixed  = rx_word;
        dec_corr   = 1'b0;
        dec_uncorr = 1'b0;
        if (^rx_word) begin
            dec_corr = 1'b1;
            for (int pos = 0; pos < CW; pos++)
                if (pos == dec_syn) dec_fixed[pos] = ~rx_word[pos];
        end else if (dec_syn != 0) begin
            dec_uncorr = 1'b1;
        end
        dec_data = extract(dec_fixed);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_q   <= '0;
            valid_q  <= 1'b0;
            corr_q   <= 1'b0;
            uncorr_q <= 1'b0;
        end else begin
            valid_q  <= frame_done;
            corr_q   <= frame_done && dec_corr;
            uncorr_q <= frame_done && dec_uncorr;
            if (frame_done) data_q <= dec_data;
        end
    end

    // Clear takes priority over an increment landing on the same edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (bus.cnt_clear_i) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else begin
            if (frame_done && dec_corr && (corr_cnt != '1))
                corr_cnt <= corr_cnt + 1'b1;
            if (frame_done && dec_uncorr && (uncorr_cnt != '1))
                uncorr_cnt <= uncorr_cnt + 1'b1;
        end
    end

    assign bus.ready_out_o         = !full;
    assign bus.fifo_full_o         = full;
    assign bus.fifo_empty_o        = empty;
    assign bus.serial_data_o       = serial;
    assign bus.serial_valid_o      = (state == ST_SHIFT);
    assign bus.parallel_out_o      = data_q;
    assign bus.valid_out_o         = valid_q;
    assign bus.err_corrected_o     = corr_q;
    assign bus.err_uncorrectable_o = uncorr_q;
    assign bus.corr_count_o        = corr_cnt;
    assign bus.uncorr_count_o      = uncorr_cnt;
endmodule

// File: tb/tb_serdes_ecc_lanes.sv
// Directed bench for serdes_ecc_lanes: a single-lane instance (A) and a
// four-lane instance with 2-bit counters (B) share clock and reset.
module tb_serdes_ecc_lanes;
    logic clk;
    logic rst_n;

    int checks   = 0;
    int failures = 0;

    serdes_ecc_lanes_if #(.DATA_WIDTH(8), .LANES(1), .CNT_W(16)) a_bus ();
    serdes_ecc_lanes_if #(.DATA_WIDTH(8), .LANES(4), .CNT_W(2))  b_bus ();

    serdes_ecc_lanes #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .LANES(1), .CNT_W(16)) dut_a (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (a_bus.slave)
    );

    serdes_ecc_lanes #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .LANES(4), .CNT_W(2)) dut_b (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (b_bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          a_edges;
    int          a_beat;
    logic        a_got;
    logic [15:0] a_frame;
    logic [7:0]  a_dout;
    logic        a_corr;
    logic        a_uncorr;

    int          b_edges;
    logic        b_got;
    logic [7:0]  b_dout;
    logic        b_corr;
    logic        b_uncorr;

    logic [7:0]  rx_q [$];
    logic [7:0]  b_rx [$];
    logic [7:0]  b_words [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Push one word into A and follow it to its decoded pulse, recording the serial frame.
    task automatic send_a(input logic [7:0] data, input logic [12:0] mask);
        a_bus.parallel_in_i = data;
        a_bus.inject_mask_i = mask;
        a_bus.valid_in_i    = 1'b1;
        tick();
        a_bus.valid_in_i = 1'b0;
        a_edges = 0;
        a_beat  = 0;
        a_got   = 1'b0;
        a_frame = '0;
        while (!a_got && a_edges < 60) begin
            tick();
            a_edges++;
            if (a_bus.serial_valid_o && a_beat < 16) begin
                a_frame[a_beat] = a_bus.serial_data_o[0];
                a_beat++;
            end
            if (a_bus.valid_out_o) begin
                a_got    = 1'b1;
                a_dout   = a_bus.parallel_out_o;
                a_corr   = a_bus.err_corrected_o;
                a_uncorr = a_bus.err_uncorrectable_o;
            end
        end
        a_bus.inject_mask_i = '0;
    endtask

    task automatic send_b(input logic [7:0] data, input logic [12:0] mask);
        b_bus.parallel_in_i = data;
        b_bus.inject_mask_i = mask;
        b_bus.valid_in_i    = 1'b1;
        tick();
        b_bus.valid_in_i = 1'b0;
        b_edges = 0;
        b_got   = 1'b0;
        while (!b_got && b_edges < 60) begin
            tick();
            b_edges++;
            if (b_bus.valid_out_o) begin
                b_got    = 1'b1;
                b_dout   = b_bus.parallel_out_o;
                b_corr   = b_bus.err_corrected_o;
                b_uncorr = b_bus.err_uncorrectable_o;
            end
        end
        b_bus.inject_mask_i = '0;
    endtask

    initial begin
        int next_data;
        int pushed;
        int first_low;
        int first_v;
        int pulses;
        int exp_sv;
        logic acc;
        logic full_at_low;

        b_words = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h81, 8'h7E, 8'h01, 8'h80};

        rst_n = 1'b0;
        a_bus.parallel_in_i = '0;  a_bus.valid_in_i = 1'b0;
        a_bus.inject_mask_i = '0;  a_bus.cnt_clear_i = 1'b0;
        b_bus.parallel_in_i = '0;  b_bus.valid_in_i = 1'b0;
        b_bus.inject_mask_i = '0;  b_bus.cnt_clear_i = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        $display("[TB] reset state");
        check_output("rst_ready",        32'(a_bus.ready_out_o), 1);
        check_output("rst_empty",        32'(a_bus.fifo_empty_o), 1);
        check_output("rst_full",         32'(a_bus.fifo_full_o), 0);
        check_output("rst_valid_out",    32'(a_bus.valid_out_o), 0);
        check_output("rst_serial_valid", 32'(a_bus.serial_valid_o), 0);
        check_output("rst_parallel_out", 32'(a_bus.parallel_out_o), 0);
        check_output("rst_corr_count",   32'(a_bus.corr_count_o), 0);
        check_output("rst_b_empty",      32'(b_bus.fifo_empty_o), 1);

        $display("[TB] clean word 0xA5 on one lane");
        send_a(8'hA5, 13'h0000);
        check_output("t1_latency",  32'(a_edges), 15);
        check_output("t1_data",     32'(a_dout), 'hA5);
        check_output("t1_corr",     32'(a_corr), 0);
        check_output("t1_uncorr",   32'(a_uncorr), 0);
        check_output("t1_frame",    32'(a_frame), 'h144E);
        check_output("t1_corr_cnt", 32'(a_bus.corr_count_o), 0);
        check_output("t1_unc_cnt",  32'(a_bus.uncorr_count_o), 0);
        tick();
        check_output("t1_pulse_end", 32'(a_bus.valid_out_o), 0);
        check_output("t1_hold",      32'(a_bus.parallel_out_o), 'hA5);

        $display("[TB] single error on codeword bit 3");
        send_a(8'h3C, 13'h0008);
        check_output("t2_data",     32'(a_dout), 'h3C);
        check_output("t2_corr",     32'(a_corr), 1);
        check_output("t2_uncorr",   32'(a_uncorr), 0);
        check_output("t2_corr_cnt", 32'(a_bus.corr_count_o), 1);
        tick();
        check_output("t2_flag_low", 32'(a_bus.err_corrected_o), 0);
        check_output("t2_hold",     32'(a_bus.parallel_out_o), 'h3C);

        $display("[TB] double error on codeword bits 2 and 5");
        send_a(8'h0F, 13'h0024);
        check_output("t3_corr",     32'(a_corr), 0);
        check_output("t3_uncorr",   32'(a_uncorr), 1);
        check_output("t3_unc_cnt",  32'(a_bus.uncorr_count_o), 1);
        check_output("t3_corr_cnt", 32'(a_bus.corr_count_o), 1);

        $display("[TB] single error on the overall parity bit");
        send_a(8'h5A, 13'h0001);
        check_output("t3b_data",     32'(a_dout), 'h5A);
        check_output("t3b_corr",     32'(a_corr), 1);
        check_output("t3b_corr_cnt", 32'(a_bus.corr_count_o), 2);

        $display("[TB] 40-cycle back-pressure stream on one lane");
        next_data = 0;
        pushed    = 0;
        first_low = -1;
        full_at_low = 1'b0;
        rx_q.delete();
        for (int i = 0; i < 40; i++) begin
            a_bus.parallel_in_i = 8'(next_data);
            a_bus.valid_in_i    = 1'b1;
            if (!a_bus.ready_out_o && first_low < 0) begin
                first_low   = i;
                full_at_low = a_bus.fifo_full_o;
            end
            acc = a_bus.ready_out_o;
            tick();
            if (acc) begin
                pushed++;
                next_data++;
            end
            if (a_bus.valid_out_o) rx_q.push_back(a_bus.parallel_out_o);
        end
        a_bus.valid_in_i = 1'b0;
        for (int i = 0; i < 400 && rx_q.size() < 19; i++) begin
            tick();
            if (a_bus.valid_out_o) rx_q.push_back(a_bus.parallel_out_o);
        end
        check_output("t4_pushed",    32'(pushed), 19);
        check_output("t4_first_low", 32'(first_low), 18);
        check_output("t4_full",      32'(full_at_low), 1);
        check_output("t4_rx_count",  32'(rx_q.size()), 19);
        for (int k = 0; k < rx_q.size(); k++)
            check_output($sformatf("t4_word%0d", k), 32'(rx_q[k]), k);
        check_output("t4_drained", 32'(a_bus.fifo_empty_o), 1);

        $display("[TB] four-lane burst of 8 words");
        first_v = -1;
        b_rx.delete();
        for (int k = 0; k < 46; k++) begin
            if (k < 8) begin
                b_bus.parallel_in_i = b_words[k];
                b_bus.valid_in_i    = 1'b1;
            end else begin
                b_bus.valid_in_i = 1'b0;
            end
            tick();
            exp_sv = (k >= 1 && k <= 39 && ((k - 1) % 5) < 4) ? 1 : 0;
            check_output($sformatf("t5_sv_k%0d", k), 32'(b_bus.serial_valid_o), exp_sv);
            if (b_bus.valid_out_o) begin
                if (first_v < 0) first_v = k;
                b_rx.push_back(b_bus.parallel_out_o);
            end
        end
        check_output("t5_latency",  32'(first_v), 6);
        check_output("t5_rx_count", 32'(b_rx.size()), 8);
        for (int k = 0; k < b_rx.size() && k < 8; k++)
            check_output($sformatf("t5_word%0d", k), 32'(b_rx[k]), 32'(b_words[k]));

        $display("[TB] counter saturation with 2-bit counters");
        for (int n = 0; n < 5; n++) begin
            send_b(8'(8'h30 + n), 13'h0020);
            if (n == 0) check_output("t6_latency", 32'(b_edges), 6);
            check_output($sformatf("t6_data%0d", n), 32'(b_dout), 32'(8'h30 + n));
            check_output($sformatf("t6_corr%0d", n), 32'(b_corr), 1);
            check_output($sformatf("t6_cnt%0d", n), 32'(b_bus.corr_count_o), (n < 3) ? n + 1 : 3);
        end
        check_output("t6_unc_cnt", 32'(b_bus.uncorr_count_o), 0);

        b_bus.parallel_in_i = 8'h44;
        b_bus.inject_mask_i = 13'h0020;
        b_bus.valid_in_i    = 1'b1;
        tick();
        b_bus.valid_in_i = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check_output("t6_pre_clear_cnt", 32'(b_bus.corr_count_o), 3);
        b_bus.cnt_clear_i = 1'b1;
        tick();
        b_bus.cnt_clear_i   = 1'b0;
        b_bus.inject_mask_i = '0;
        check_output("t6_clr_valid", 32'(b_bus.valid_out_o), 1);
        check_output("t6_clr_corr",  32'(b_bus.err_corrected_o), 1);
        check_output("t6_clr_cnt",   32'(b_bus.corr_count_o), 0);

        $display("[TB] reset during serial shift");
        a_bus.parallel_in_i = 8'h77;
        a_bus.valid_in_i    = 1'b1;
        tick();
        a_bus.parallel_in_i = 8'h88;
        tick();
        a_bus.valid_in_i = 1'b0;
        tick();
        tick();
        check_output("t7_pre_shift", 32'(a_bus.serial_valid_o), 1);
        check_output("t7_pre_occ",   32'(a_bus.fifo_empty_o), 0);
        rst_n = 1'b0;
        #1;
        check_output("t7_empty",     32'(a_bus.fifo_empty_o), 1);
        check_output("t7_ready",     32'(a_bus.ready_out_o), 1);
        check_output("t7_sv",        32'(a_bus.serial_valid_o), 0);
        check_output("t7_corr_cnt",  32'(a_bus.corr_count_o), 0);
        check_output("t7_unc_cnt",   32'(a_bus.uncorr_count_o), 0);
        check_output("t7_data",      32'(a_bus.parallel_out_o), 0);
        tick();
        tick();
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (a_bus.valid_out_o) pulses++;
        end
        check_output("t7_no_pulse",  32'(pulses), 0);
        check_output("t7_still_empty", 32'(a_bus.fifo_empty_o), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
